// File: rtl/rd_pkg.sv
// -----------------------------------------------------------------------------
// rd_pkg
// Shared definitions for the SRAM result reader: FSM state encoding and the
// default values of the reader's parameters.
// -----------------------------------------------------------------------------
package rd_pkg;

  // Default index/address width; out_idx and max_idx share the SRAM address width.
  localparam int RD_IDX_W     = 8;
  localparam int RD_DATA_W    = 32;
  localparam int RD_NUM_WORDS = 16;
  localparam int RD_BASE_ADDR = 0;
  localparam int RD_TIMEOUT   = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_OUT,
    ST_DONE
  } rd_state_t;

endpackage

// File: rtl/rd_max_tracker.sv
// -----------------------------------------------------------------------------
// rd_max_tracker
// Keeps the largest (unsigned) word seen in a run and the index of its first
// occurrence.
//   clk, rst        : clock, asynchronous active-high reset
//   clr             : zero the tracker (start of a run)
//   upd_en          : a word is being captured this cycle
//   first           : the captured word is word 0 (always loads)
//   upd_data/upd_idx: captured word and its index
//   max_data/max_idx: running maximum and its index
// -----------------------------------------------------------------------------
module rd_max_tracker
  import rd_pkg::*;
#(
  parameter int IDX_W  = RD_IDX_W,
  parameter int DATA_W = RD_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              upd_en,
  input  logic              first,
  input  logic [DATA_W-1:0] upd_data,
  input  logic [IDX_W-1:0]  upd_idx,
  output logic [DATA_W-1:0] max_data,
  output logic [IDX_W-1:0]  max_idx
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_data <= '0;
      max_idx  <= '0;
    end else if (clr) begin
      max_data <= '0;
      max_idx  <= '0;
    end else if (upd_en && (first || (upd_data > max_data))) begin
      // Strict compare: a later word equal to the maximum keeps the earlier index.
      max_data <= upd_data;
      max_idx  <= upd_idx;
    end
  end

endmodule

// File: rtl/sram_result_reader.sv
// -----------------------------------------------------------------------------
// sram_result_reader
// After start (ALU_done), owns the SRAM port and reads NUM_WORDS words from
// BASE_ADDR upward, waiting on sram_ry for each. Every word is offered on a
// valid/ready stream; the largest word and its index are tracked, and a
// one-cycle rd_done pulse ends the run. A word that never becomes ready within
// TIMEOUT wait cycles aborts the run with the sticky rd_err flag.
//   clk, rst                 : clock, asynchronous active-high reset
//   start                    : run request (sampled in IDLE only)
//   sram_cs_n/we_n/addr      : SRAM control (we_n is always 1, read-only)
//   sram_ry, sram_rdata      : SRAM ready and same-cycle read data
//   out_data/idx/valid/ready : result word stream
//   rd_busy                  : block owns the SRAM port
//   max_data, max_idx        : largest word of the last run, first index
//   rd_done, rd_err          : end-of-run pulse, sticky timeout flag
// -----------------------------------------------------------------------------
module sram_result_reader
  import rd_pkg::*;
#(
  parameter int ADDR_W    = RD_IDX_W,
  parameter int DATA_W    = RD_DATA_W,
  parameter int NUM_WORDS = RD_NUM_WORDS,
  parameter int BASE_ADDR = RD_BASE_ADDR,
  parameter int TIMEOUT   = RD_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              sram_cs_n,
  output logic              sram_we_n,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic              sram_ry,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              rd_busy,
  output logic [DATA_W-1:0] max_data,
  output logic [ADDR_W-1:0] max_idx,
  output logic              rd_done,
  output logic              rd_err
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_WORDS - 1);
  // The counter holds the number of WAIT cycles already spent; the TIMEOUT-th
  // cycle without ry is the one that sees TIMEOUT-1.
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);

  rd_state_t         state_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;

  logic run_start;
  logic capture;

  assign run_start = (state_reg == ST_IDLE) && start;
  assign capture   = (state_reg == ST_WAIT) && sram_ry;
  assign sram_we_n = 1'b1;

  rd_max_tracker #(
    .IDX_W  (ADDR_W),
    .DATA_W (DATA_W)
  ) u_max (
    .clk      (clk),
    .rst      (rst),
    .clr      (run_start),
    .upd_en   (capture),
    .first    (idx_reg == '0),
    .upd_data (sram_rdata),
    .upd_idx  (idx_reg),
    .max_data (max_data),
    .max_idx  (max_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      sram_cs_n    <= 1'b1;
      sram_addr    <= BASE;
      idx_reg      <= '0;
      wait_cnt_reg <= '0;
      out_data     <= '0;
      out_idx      <= '0;
      out_valid    <= 1'b0;
      rd_busy      <= 1'b0;
      rd_done      <= 1'b0;
      rd_err       <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_REQ;
            sram_addr <= BASE;
            idx_reg   <= '0;
            rd_err    <= 1'b0;
            rd_busy   <= 1'b1;
          end
        end
        ST_REQ: begin
          sram_cs_n    <= 1'b0;
          wait_cnt_reg <= '0;
          state_reg    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sram_ry) begin
            out_data  <= sram_rdata;
            out_idx   <= idx_reg;
            out_valid <= 1'b1;
            sram_cs_n <= 1'b1;
            state_reg <= ST_OUT;
          end else if (wait_cnt_reg == WAIT_LIMIT) begin
            rd_err    <= 1'b1;
            sram_cs_n <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx_reg == LAST_IDX) begin
              state_reg <= ST_DONE;
            end else begin
              // Address wraps naturally modulo 2^ADDR_W.
              idx_reg   <= idx_reg + 1'b1;
              sram_addr <= sram_addr + 1'b1;
              state_reg <= ST_REQ;
            end
          end
        end
        ST_DONE: begin
          rd_done   <= 1'b1;
          rd_busy   <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
